ahb_bm_input_stage: RTL and testbench

Per-master input stage of the AHB bus matrix. It sits between one master (slave-side AHB port) and the per-slave output arbiters/output stages. It registers an address phase that the fixed-priority output arbiter cannot grant immediately, and holds the master with HREADYOUTS low until the grant arrives. It raises the request that drives the arbiter's req_portN input, and routes the granted slave's ready and response back to the master.

---
 rtl/ahb_bm_pkg.sv | 30 +++
 rtl/ahb_bm_addr_hold_reg.sv | 48 ++++
 rtl/ahb_bm_input_stage.sv | 144 ++++++++++++++
 tb/tb_ahb_bm_input_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// Shared AHB encodings for the bus-matrix input and output stages.
package ahb_bm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // NONSEQ and SEQ both carry bit 1 set; IDLE and BUSY request nothing.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_bm_addr_hold_reg.sv
// Address/control holding register: captures the master's address phase
// whenever it is accepted so it can be replayed while waiting for a grant.
module ahb_bm_addr_hold_reg
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            trans,
  input  logic                  write,
  input  logic [2:0]            size,
  input  logic [2:0]            burst,
  input  logic [3:0]            prot,
  input  logic                  mastlock,
  output logic [ADDR_WIDTH-1:0] held_addr,
  output logic [1:0]            held_trans,
  output logic                  held_write,
  output logic [2:0]            held_size,
  output logic [2:0]            held_burst,
  output logic [3:0]            held_prot,
  output logic                  held_mastlock
);

  // Capture every accepted address phase, IDLE included.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_addr     <= '0;
      held_trans    <= HTRANS_IDLE;
      held_write    <= 1'b0;
      held_size     <= 3'b000;
      held_burst    <= HBURST_SINGLE;
      held_prot     <= 4'b0000;
      held_mastlock <= 1'b0;
    end else if (load) begin
      held_addr     <= addr;
      held_trans    <= trans;
      held_write    <= write;
      held_size     <= size;
      held_burst    <= burst;
      held_prot     <= prot;
      held_mastlock <= mastlock;
    end
  end

endmodule

// File: rtl/ahb_bm_input_stage.sv
// Per-master input stage of the AHB bus matrix: buffers an address phase the
// output arbiter cannot grant yet, stalls the master until it is issued, and
// returns the granted slave's ready/response to the master.
module ahb_bm_input_stage
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PORT_ID    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  req_out,
  output logic                  held_tran,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  mastlock_out,
  input  logic                  active_in,
  input  logic                  readyout_in,
  input  logic                  resp_in
);

  logic                  new_tran;
  logic                  load;
  logic                  grant;
  logic                  busy;
  logic                  pend;
  logic                  dphase;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [1:0]            held_trans;
  logic                  held_write;
  logic [2:0]            held_size;
  logic [2:0]            held_burst;
  logic [3:0]            held_prot;
  logic                  held_mastlock;

  assign new_tran = HSELS & HREADYS & is_active_trans(HTRANSS);
  assign load     = HSELS & HREADYS;
  assign grant    = active_in & readyout_in;
  // A transfer is outstanding when it is either arriving now or already held.
  assign busy     = new_tran | pend;

  assign req_out   = busy;
  assign held_tran = pend;

  ahb_bm_addr_hold_reg #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .load          (load),
    .addr          (HADDRS),
    .trans         (HTRANSS),
    .write         (HWRITES),
    .size          (HSIZES),
    .burst         (HBURSTS),
    .prot          (HPROTS),
    .mastlock      (HMASTLOCKS),
    .held_addr     (held_addr),
    .held_trans    (held_trans),
    .held_write    (held_write),
    .held_size     (held_size),
    .held_burst    (held_burst),
    .held_prot     (held_prot),
    .held_mastlock (held_mastlock)
  );

  // Keep a transfer pending until the arbiter grants it on a ready slave path.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= 1'b0;
    end else begin
      pend <= busy & ~grant;
    end
  end

  // Track ownership of a slave data phase; it ends on the slave's ready unless
  // a new transfer is issued in that same cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase <= 1'b0;
    end else if (busy & grant) begin
      dphase <= 1'b1;
    end else if (readyout_in) begin
      dphase <= 1'b0;
    end
  end

  // Drive the output stage from the held copy while waiting, else from the master.
  always_comb begin
    addr_out     = HADDRS;
    trans_out    = HSELS ? HTRANSS : HTRANS_IDLE;
    write_out    = HWRITES;
    size_out     = HSIZES;
    burst_out    = HBURSTS;
    prot_out     = HPROTS;
    mastlock_out = HMASTLOCKS;
    if (pend) begin
      addr_out     = held_addr;
      trans_out    = held_trans;
      write_out    = held_write;
      size_out     = held_size;
      burst_out    = held_burst;
      prot_out     = held_prot;
      mastlock_out = held_mastlock;
    end
  end

  // Stall the master while waiting; otherwise reflect the owned data phase.
  always_comb begin
    HREADYOUTS = 1'b1;
    if (pend) begin
      HREADYOUTS = 1'b0;
    end else if (dphase) begin
      HREADYOUTS = readyout_in;
    end
    HRESPS = dphase ? resp_in : HRESP_OKAY;
  end

  // The master is stalled while a transfer is held, so nothing new can arrive.
  property p_no_new_while_pend;
    @(posedge HCLK) disable iff (!HRESETn) pend |-> !new_tran;
  endproperty

  a_no_new_while_pend : assert property (p_no_new_while_pend)
    else $error("ahb_bm_input_stage port %0d: new transfer while one is held", PORT_ID);

  c_pend_released : cover property (@(posedge HCLK) disable iff (!HRESETn) pend ##1 !pend);

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Self-checking bench for ahb_bm_input_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_ahb_bm_input_stage;
  import ahb_bm_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        req_out;
  logic        held_tran;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic        write_out;
  logic [2:0]  size_out;
  logic [2:0]  burst_out;
  logic [3:0]  prot_out;
  logic        mastlock_out;
  logic        active_in;
  logic        readyout_in;
  logic        resp_in;

  int checks = 0;
  int errors = 0;

  // Model state: a transfer waiting for its grant, and ownership of a data phase.
  bit    m_wait = 1'b0;
  bit    m_own  = 1'b0;
  xfer_t m_buf  = '0;

  always #5 HCLK = ~HCLK;

  // Single-slave master layer: the master sees this port's ready directly.
  assign HREADYS = HREADYOUTS;

  ahb_bm_input_stage #(
    .ADDR_WIDTH (32),
    .PORT_ID    (0)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HBURSTS      (HBURSTS),
    .HPROTS       (HPROTS),
    .HMASTLOCKS   (HMASTLOCKS),
    .HREADYS      (HREADYS),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .req_out      (req_out),
    .held_tran    (held_tran),
    .addr_out     (addr_out),
    .trans_out    (trans_out),
    .write_out    (write_out),
    .size_out     (size_out),
    .burst_out    (burst_out),
    .prot_out     (prot_out),
    .mastlock_out (mastlock_out),
    .active_in    (active_in),
    .readyout_in  (readyout_in),
    .resp_in      (resp_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic [1:0] tr, input logic [31:0] a, input bit wr,
                       input bit act, input bit rdy, input bit rsp);
    HSELS       = sel;
    HTRANSS     = tr;
    HADDRS      = a;
    HWRITES     = wr;
    HSIZES      = 3'd2;
    HBURSTS     = HBURST_SINGLE;
    HPROTS      = 4'h3;
    HMASTLOCKS  = 1'b0;
    active_in   = act;
    readyout_in = rdy;
    resp_in     = rsp;
  endtask

  // Compare all outputs against the model for the current cycle, then advance
  // the model across the coming clock edge.
  task automatic step();
    xfer_t live;
    xfer_t bus;
    bit    exp_rdy;
    bit    accepted;
    bit    outstanding;
    bit    issued;
    #1;
    if (!HRESETn) begin
      m_wait = 1'b0;
      m_own  = 1'b0;
      m_buf  = '0;
    end
    live = '{HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
    exp_rdy     = m_wait ? 1'b0 : (m_own ? readyout_in : 1'b1);
    accepted    = HSELS && exp_rdy && (HTRANSS == HTRANS_NONSEQ || HTRANSS == HTRANS_SEQ);
    outstanding = m_wait || accepted;
    bus = m_wait ? m_buf : live;
    if (!m_wait && !HSELS) bus.trans = HTRANS_IDLE;

    chk("hreadyout", 32'(HREADYOUTS), 32'(exp_rdy));
    chk("hresp",     32'(HRESPS),     32'(m_own ? resp_in : HRESP_OKAY));
    chk("req",       32'(req_out),    32'(outstanding));
    chk("held",      32'(held_tran),  32'(m_wait));
    chk("addr",      addr_out,        bus.addr);
    chk("trans",     32'(trans_out),  32'(bus.trans));
    chk("write",     32'(write_out),  32'(bus.write));
    chk("size",      32'(size_out),   32'(bus.size));
    chk("burst",     32'(burst_out),  32'(bus.burst));
    chk("prot",      32'(prot_out),   32'(bus.prot));
    chk("lock",      32'(mastlock_out), 32'(bus.lock));

    if (HRESETn) begin
      issued = outstanding && active_in && readyout_in;
      if (accepted && !issued) m_buf = live;
      if (issued)           m_own = 1'b1;
      else if (readyout_in) m_own = 1'b0;
      m_wait = outstanding && !issued;
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(0, HTRANS_IDLE, 32'h0, 0, 0, 0, 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // Out of reset: idle, ready, OKAY, no request.
    step();
    chk("rst_hready", 32'(HREADYOUTS), 32'd1);
    chk("rst_req",    32'(req_out),    32'd0);
    chk("rst_trans",  32'(trans_out),  32'(HTRANS_IDLE));
    @(negedge HCLK);

    // Granted immediately: passes straight through with no hold.
    drive(1, HTRANS_NONSEQ, 32'h0000_0100, 0, 1, 1, 0);
    step();
    chk("grant_trans", 32'(trans_out), 32'(HTRANS_NONSEQ));
    chk("grant_addr",  addr_out,       32'h0000_0100);
    chk("grant_held",  32'(held_tran), 32'd0);
    @(negedge HCLK);
    drive(0, HTRANS_IDLE, 32'h0, 0, 0, 0, 0);
    step();
    chk("grant_dp_wait", 32'(HREADYOUTS), 32'd0);
    @(negedge HCLK);
    drive(0, HTRANS_IDLE, 32'h0, 0, 0, 1, 0);
    step();
    chk("grant_dp_done", 32'(HREADYOUTS), 32'd1);
    @(negedge HCLK);

    // Not granted for 3 cycles: held while the master's bus wanders.
    drive(1, HTRANS_NONSEQ, 32'h4000_0010, 1, 0, 1, 0);
    step();
    chk("hold_req", 32'(req_out), 32'd1);
    @(negedge HCLK);
    for (int k = 0; k < 3; k++) begin
      drive(1, HTRANS_NONSEQ, $urandom, 0, 0, 1, 0);
      step();
      chk("hold_held",  32'(held_tran),  32'd1);
      chk("hold_ready", 32'(HREADYOUTS), 32'd0);
      chk("hold_addr",  addr_out,        32'h4000_0010);
      chk("hold_write", 32'(write_out),  32'd1);
      @(negedge HCLK);
    end
    drive(1, HTRANS_SEQ, $urandom, 0, 1, 1, 0);
    step();
    chk("issue_addr", addr_out, 32'h4000_0010);
    @(negedge HCLK);
    // Data phase with two slave wait states.
    for (int k = 0; k < 2; k++) begin
      drive(0, HTRANS_IDLE, 32'h0, 0, 0, 0, 0);
      step();
      chk("ws_ready", 32'(HREADYOUTS), 32'd0);
      @(negedge HCLK);
    end
    drive(0, HTRANS_IDLE, 32'h0, 0, 0, 1, 0);
    step();
    chk("ws_done", 32'(HREADYOUTS), 32'd1);
    chk("ws_resp", 32'(HRESPS),     32'(HRESP_OKAY));
    @(negedge HCLK);

    // Two-cycle ERROR response, master cancels with IDLE.
    drive(1, HTRANS_NONSEQ, 32'h8000_0000, 0, 1, 1, 0);
    step();
    @(negedge HCLK);
    drive(1, HTRANS_NONSEQ, 32'h8000_0004, 0, 1, 0, 1);
    step();
    chk("err1_resp",  32'(HRESPS),     32'd1);
    chk("err1_ready", 32'(HREADYOUTS), 32'd0);
    @(negedge HCLK);
    drive(1, HTRANS_IDLE, 32'h8000_0004, 0, 1, 1, 1);
    step();
    chk("err2_resp",  32'(HRESPS),     32'd1);
    chk("err2_ready", 32'(HREADYOUTS), 32'd1);
    chk("err2_trans", 32'(trans_out),  32'(HTRANS_IDLE));
    @(negedge HCLK);

    // Locked INCR4 burst keeps its grant on every beat.
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h1000 + 32'(4 * i), 1, 1, 1, 0);
      HBURSTS    = HBURST_INCR4;
      HMASTLOCKS = 1'b1;
      step();
      chk("lock_out",  32'(mastlock_out), 32'd1);
      chk("lock_held", 32'(held_tran),    32'd0);
      chk("lock_req",  32'(req_out),      32'd1);
      @(negedge HCLK);
    end

    // Reset while a transfer is held.
    drive(1, HTRANS_NONSEQ, 32'h2000_0000, 0, 0, 1, 0);
    step();
    @(negedge HCLK);
    drive(1, HTRANS_NONSEQ, 32'h2000_0000, 0, 0, 1, 0);
    step();
    chk("mid_held", 32'(held_tran), 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b0;
    drive(0, HTRANS_IDLE, 32'h2000_0000, 0, 0, 1, 0);
    step();
    chk("midrst_ready", 32'(HREADYOUTS), 32'd1);
    chk("midrst_held",  32'(held_tran),  32'd0);
    chk("midrst_trans", 32'(trans_out),  32'(HTRANS_IDLE));
    chk("midrst_req",   32'(req_out),    32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    chk("postrst_held", 32'(held_tran), 32'd0);
    @(negedge HCLK);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      HRESETn     = ($urandom_range(0, 99) != 0);
      HSELS       = ($urandom_range(0, 3) != 0);
      HTRANSS     = 2'($urandom_range(0, 3));
      HADDRS      = $urandom;
      HWRITES     = 1'($urandom_range(0, 1));
      HSIZES      = 3'($urandom_range(0, 7));
      HBURSTS     = 3'($urandom_range(0, 7));
      HPROTS      = 4'($urandom_range(0, 15));
      HMASTLOCKS  = 1'($urandom_range(0, 1));
      active_in   = ($urandom_range(0, 2) != 0);
      readyout_in = ($urandom_range(0, 3) != 0);
      resp_in     = ($urandom_range(0, 7) == 0);
      step();
      @(negedge HCLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
